// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback controller: decode, condition check, ALU drive, register file and NZCV
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [31:0] i_instr,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [3:0]  o_alu_op,
    output logic [3:0]  o_alu_cond,
    output logic [2:0]  o_alu_ls,
    output logic        o_alu_s,
    output logic [4:0]  o_alu_rotbit,
    input  logic [31:0] i_alu_y,
    input  logic        i_alu_n,
    input  logic        i_alu_z,
    input  logic        i_alu_c,
    input  logic        i_alu_v,
    output logic        o_retire_valid,
    output logic        o_retire_exec,
    output logic [3:0]  o_flags,
    input  logic        i_dbg_we,
    input  logic [3:0]  i_dbg_waddr,
    input  logic [31:0] i_dbg_wdata,
    input  logic [3:0]  i_dbg_raddr,
    output logic [31:0] o_dbg_rdata
);

    localparam logic [3:0] LP_LAT    = ALU_LAT[3:0];
    localparam logic [3:0] LP_OP_CMP = 4'b1000;
    localparam logic [3:0] LP_OP_NOP = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_SKIP
    } state_t;

    state_t      r_state;
    logic [31:3] r_instr;
    logic [31:0] r_regs [NREGS];
    logic [3:0]  r_lat_cnt;
    logic [3:0]  r_flags;
    logic        r_ready;
    logic        r_retire_valid;
    logic        r_retire_exec;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [3:0]  r_alu_op;
    logic [2:0]  r_alu_ls;
    logic        r_alu_s;
    logic [4:0]  r_alu_rotbit;

    logic [3:0]  w_op;
    logic [3:0]  w_cond;
    logic        w_s;
    logic [3:0]  w_rd;
    logic [3:0]  w_rn;
    logic [3:0]  w_rm;
    logic        w_accept;
    logic        w_cond_pass;
    logic        w_wb_we;
    logic        w_dbg_we;
    logic        w_n, w_z, w_c, w_v;
    logic        w_unused;

    assign w_op     = r_instr[31:28];
    assign w_cond   = r_instr[27:24];
    assign w_s      = r_instr[20];
    assign w_rd     = r_instr[19:16];
    assign w_rn     = r_instr[15:12];
    assign w_rm     = r_instr[11:8];
    assign w_unused = &{1'b0, i_instr[2:0]};

    assign {w_n, w_z, w_c, w_v} = r_flags;

    assign w_accept = i_instr_valid && r_ready;
    assign w_wb_we  = (r_state == S_WB) && (w_op != LP_OP_CMP);
    // A debug write loses to an instruction handshake in the same cycle
    assign w_dbg_we = i_dbg_we && (r_state == S_IDLE) && !w_accept;

    assign o_instr_ready  = r_ready;
    assign o_retire_valid = r_retire_valid;
    assign o_retire_exec  = r_retire_exec;
    assign o_flags        = r_flags;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_op       = r_alu_op;
    assign o_alu_cond     = 4'b0000;
    assign o_alu_ls       = r_alu_ls;
    assign o_alu_s        = r_alu_s;
    assign o_alu_rotbit   = r_alu_rotbit;
    assign o_dbg_rdata    = r_regs[i_dbg_raddr];

    // Condition code evaluated against the flags as they stand in READ
    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            4'b0000: w_cond_pass = 1'b1;
            4'b0001: w_cond_pass = w_z;
            4'b0010: w_cond_pass = !w_z && (w_n == w_v);
            4'b0011: w_cond_pass = (w_n != w_v);
            4'b0100: w_cond_pass = (w_n == w_v);
            4'b0101: w_cond_pass = (w_n != w_v) || w_z;
            4'b0110: w_cond_pass = w_c && !w_z;
            4'b0111: w_cond_pass = !w_c || w_z;
            4'b1000: w_cond_pass = (w_n == w_v);
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Register file: writeback in WB, debug port only while idle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[w_rd] <= i_alu_y;
        end else if (w_dbg_we) begin
            r_regs[i_dbg_waddr] <= i_dbg_wdata;
        end
    end

    // Issue FSM with registered handshake, ALU drive, retire and flag outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_instr        <= '0;
            r_lat_cnt      <= '0;
            r_flags        <= 4'b0000;
            r_ready        <= 1'b1;
            r_retire_valid <= 1'b0;
            r_retire_exec  <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= LP_OP_NOP;
            r_alu_ls       <= '0;
            r_alu_s        <= 1'b0;
            r_alu_rotbit   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_instr <= i_instr[31:3];
                        r_ready <= 1'b0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_cond_pass) begin
                        r_alu_a      <= r_regs[w_rn];
                        r_alu_b      <= r_regs[w_rm];
                        r_alu_op     <= w_op;
                        r_alu_ls     <= r_instr[23:21];
                        r_alu_s      <= w_s;
                        r_alu_rotbit <= r_instr[7:3];
                        r_lat_cnt    <= 4'd1;
                        r_state      <= S_EXEC;
                    end else begin
                        r_retire_valid <= 1'b1;
                        r_retire_exec  <= 1'b0;
                        r_state        <= S_SKIP;
                    end
                end
                S_EXEC: begin
                    if (r_lat_cnt == LP_LAT) begin
                        r_retire_valid <= 1'b1;
                        r_retire_exec  <= 1'b1;
                        r_state        <= S_WB;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                    end
                end
                S_WB: begin
                    if (w_s || (w_op == LP_OP_CMP)) begin
                        r_flags <= {i_alu_n, i_alu_z, i_alu_c, i_alu_v};
                    end
                    r_retire_valid <= 1'b0;
                    r_retire_exec  <= 1'b0;
                    r_alu_a        <= '0;
                    r_alu_b        <= '0;
                    r_alu_op       <= LP_OP_NOP;
                    r_alu_ls       <= '0;
                    r_alu_s        <= 1'b0;
                    r_alu_rotbit   <= '0;
                    r_ready        <= 1'b1;
                    r_state        <= S_IDLE;
                end
                S_SKIP: begin
                    r_retire_valid <= 1'b0;
                    r_retire_exec  <= 1'b0;
                    r_ready        <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed and table-driven bench for alu_issue_ctrl (ALU_LAT 1 and 3)
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        dbg_we = 1'b0;
    logic [3:0]  dbg_waddr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [3:0]  dbg_raddr = '0;
    logic [3:0]  tb_nzcv = '0;

    logic        d1_ready, d1_rv, d1_rx, d1_s;
    logic [31:0] d1_a, d1_b, d1_y, d1_rdata;
    logic [3:0]  d1_op, d1_cond, d1_flags;
    logic [2:0]  d1_ls;
    logic [4:0]  d1_rot;
    logic        d2_ready, d2_rv, d2_rx, d2_s;
    logic [31:0] d2_a, d2_b, d2_y, d2_rdata;
    logic [3:0]  d2_op, d2_cond, d2_flags;
    logic [2:0]  d2_ls;
    logic [4:0]  d2_rot;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0110: return b;
            4'b1000: return a - b;
            default: return a + b;
        endcase
    endfunction

    assign d1_y = alu_fn(d1_op, d1_a, d1_b);
    assign d2_y = alu_fn(d2_op, d2_a, d2_b);

    alu_issue_ctrl #(.ALU_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(d1_ready), .i_instr(instr),
        .o_alu_a(d1_a), .o_alu_b(d1_b), .o_alu_op(d1_op), .o_alu_cond(d1_cond), .o_alu_ls(d1_ls),
        .o_alu_s(d1_s), .o_alu_rotbit(d1_rot), .i_alu_y(d1_y),
        .i_alu_n(tb_nzcv[3]), .i_alu_z(tb_nzcv[2]), .i_alu_c(tb_nzcv[1]), .i_alu_v(tb_nzcv[0]),
        .o_retire_valid(d1_rv), .o_retire_exec(d1_rx), .o_flags(d1_flags),
        .i_dbg_we(dbg_we), .i_dbg_waddr(dbg_waddr), .i_dbg_wdata(dbg_wdata),
        .i_dbg_raddr(dbg_raddr), .o_dbg_rdata(d1_rdata)
    );

    alu_issue_ctrl #(.ALU_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(d2_ready), .i_instr(instr),
        .o_alu_a(d2_a), .o_alu_b(d2_b), .o_alu_op(d2_op), .o_alu_cond(d2_cond), .o_alu_ls(d2_ls),
        .o_alu_s(d2_s), .o_alu_rotbit(d2_rot), .i_alu_y(d2_y),
        .i_alu_n(tb_nzcv[3]), .i_alu_z(tb_nzcv[2]), .i_alu_c(tb_nzcv[1]), .i_alu_v(tb_nzcv[0]),
        .o_retire_valid(d2_rv), .o_retire_exec(d2_rx), .o_flags(d2_flags),
        .i_dbg_we(dbg_we), .i_dbg_waddr(dbg_waddr), .i_dbg_wdata(dbg_wdata),
        .i_dbg_raddr(dbg_raddr), .o_dbg_rdata(d2_rdata)
    );

    typedef struct {
        logic [3:0] nzcv;
        logic [3:0] cond;
        logic       exp_exec;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] cond, input logic s,
                                       input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm);
        return {op, cond, 3'b000, s, rd, rn, rm, 5'd0, 3'b000};
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!(d1_ready && d2_ready) && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%0b/%0b expected 1/1", d1_ready, d2_ready);
        end
    endtask

    task automatic dbg_write(input logic [3:0] addr, input logic [31:0] data);
        wait_ready();
        dbg_we    = 1'b1;
        dbg_waddr = addr;
        dbg_wdata = data;
        @(negedge clk);
        dbg_we    = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
        dbg_raddr = addr;
        #1;
        chk(name, d1_rdata, exp);
    endtask

    // Issue one instruction; lat is the cycle index (accept edge = 0) of the retire pulse
    task automatic run_instr(input logic [31:0] ins, output logic ex, output int lat,
                             output logic [31:0] ca, output logic [31:0] cb, output logic saw_exec);
        ex = 1'bx; lat = 0; ca = '0; cb = '0; saw_exec = 1'b0;
        wait_ready();
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        while (lat < 40) begin
            if (d1_op != 4'b0110 || d1_a != 0 || d1_b != 0 || d1_s) begin
                saw_exec = 1'b1;
                ca = d1_a;
                cb = d1_b;
            end
            if (d1_rv) begin
                ex = d1_rx;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) begin
            checks++;
            errors++;
            $display("FAIL retire_timeout: got no retire pulse expected one");
        end
        @(negedge clk);
        chk("ready_after_retire", {31'd0, d1_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic        ex, saw;
        int          lat;
        logic [31:0] ca, cb;
        int          acc1, acc3, last1, last3;
        logic        r1, r3, pulse;

        vecs[0]  = '{4'b0000, 4'b0000, 1'b1};
        vecs[1]  = '{4'b0000, 4'b0001, 1'b0};
        vecs[2]  = '{4'b0100, 4'b0001, 1'b1};
        vecs[3]  = '{4'b0000, 4'b0010, 1'b1};
        vecs[4]  = '{4'b1000, 4'b0010, 1'b0};
        vecs[5]  = '{4'b1000, 4'b0011, 1'b1};
        vecs[6]  = '{4'b1001, 4'b0011, 1'b0};
        vecs[7]  = '{4'b1001, 4'b0100, 1'b1};
        vecs[8]  = '{4'b0100, 4'b0101, 1'b1};
        vecs[9]  = '{4'b0000, 4'b0101, 1'b0};
        vecs[10] = '{4'b0010, 4'b0110, 1'b1};
        vecs[11] = '{4'b0110, 4'b0110, 1'b0};
        vecs[12] = '{4'b0110, 4'b0111, 1'b1};
        vecs[13] = '{4'b0010, 4'b0111, 1'b0};
        vecs[14] = '{4'b1000, 4'b1000, 1'b0};
        vecs[15] = '{4'b0000, 4'b1000, 1'b1};
        vecs[16] = '{4'b1111, 4'b1011, 1'b0};
        vecs[17] = '{4'b0000, 4'b1111, 1'b0};

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", {31'd0, d1_ready}, 32'd1);
        chk("rst_retire", {30'd0, d1_rv, d1_rx}, 32'd0);
        chk("rst_alu_op", {28'd0, d1_op}, 32'd6);
        chk("rst_alu_ab", d1_a | d1_b, 32'd0);
        chk("rst_alu_misc", {19'd0, d1_cond, d1_ls, d1_s, d1_rot}, 32'd0);
        chk("rst_flags", {28'd0, d1_flags}, 32'd0);
        chk_reg("rst_r5", 4'd5, 32'd0);

        // ADD R3 = R1 + R2 with s=1
        dbg_write(4'd1, 32'd5);
        chk_reg("dbg_r1", 4'd1, 32'd5);
        dbg_write(4'd2, 32'd7);
        chk_reg("dbg_r2", 4'd2, 32'd7);
        tb_nzcv = 4'b0000;
        run_instr(mk(4'b0000, 4'b0000, 1'b1, 4'd3, 4'd1, 4'd2), ex, lat, ca, cb, saw);
        chk("add_alu_a", ca, 32'd5);
        chk("add_alu_b", cb, 32'd7);
        chk("add_exec", {31'd0, ex}, 32'd1);
        chk("add_lat", lat, 32'd3);
        chk_reg("add_r3", 4'd3, 32'd12);
        chk("add_flags", {28'd0, d1_flags}, 32'd0);

        // Condition fails (Z=0): skip, no EXEC, nothing written
        run_instr(mk(4'b0000, 4'b0001, 1'b1, 4'd3, 4'd1, 4'd1), ex, lat, ca, cb, saw);
        chk("skip_exec", {31'd0, ex}, 32'd0);
        chk("skip_lat", lat, 32'd2);
        chk("skip_no_exec_cycle", {31'd0, saw}, 32'd0);
        chk_reg("skip_r3", 4'd3, 32'd12);
        chk("skip_flags", {28'd0, d1_flags}, 32'd0);

        // CMP sets Z, writes nothing; following EQ executes
        tb_nzcv = 4'b0100;
        run_instr(mk(4'b1000, 4'b0000, 1'b0, 4'd3, 4'd1, 4'd1), ex, lat, ca, cb, saw);
        chk("cmp_flags", {28'd0, d1_flags}, 32'h4);
        chk_reg("cmp_r3", 4'd3, 32'd12);
        tb_nzcv = 4'b0000;
        run_instr(mk(4'b0000, 4'b0001, 1'b0, 4'd6, 4'd1, 4'd2), ex, lat, ca, cb, saw);
        chk("eq_exec", {31'd0, ex}, 32'd1);
        chk_reg("eq_r6", 4'd6, 32'd12);

        // Condition table: set flags with CMP, then issue a conditional non-flag-setting ADD
        for (int i = 0; i < 18; i++) begin
            tb_nzcv = vecs[i].nzcv;
            run_instr(mk(4'b1000, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0), ex, lat, ca, cb, saw);
            chk($sformatf("vec%0d_flags_set", i), {28'd0, d1_flags}, {28'd0, vecs[i].nzcv});
            tb_nzcv = ~vecs[i].nzcv;
            run_instr(mk(4'b0000, vecs[i].cond, 1'b0, 4'd6, 4'd1, 4'd2), ex, lat, ca, cb, saw);
            chk($sformatf("vec%0d_exec", i), {31'd0, ex}, {31'd0, vecs[i].exp_exec});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_exec ? 32'd3 : 32'd2);
            chk($sformatf("vec%0d_flags_kept", i), {28'd0, d1_flags}, {28'd0, vecs[i].nzcv});
        end

        // Debug write colliding with a handshake, then held during READ: both ignored
        tb_nzcv = 4'b0000;
        wait_ready();
        instr_valid = 1'b1;
        instr       = mk(4'b0000, 4'b0000, 1'b0, 4'd8, 4'd1, 4'd2);
        dbg_we      = 1'b1;
        dbg_waddr   = 4'd7;
        dbg_wdata   = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        dbg_we = 1'b0;
        wait_ready();
        chk_reg("dbg_busy_r7", 4'd7, 32'd0);
        chk_reg("dbg_busy_r8", 4'd8, 32'd12);

        // Back-to-back with valid held high: accept spacing 4 (LAT=1) and 6 (LAT=3)
        wait_ready();
        acc1 = 0; acc3 = 0; last1 = -1; last3 = -1;
        instr_valid = 1'b1;
        instr       = mk(4'b0000, 4'b0000, 1'b0, 4'd5, 4'd1, 4'd2);
        for (int e = 0; e < 24; e++) begin
            r1 = d1_ready;
            r3 = d2_ready;
            @(posedge clk);
            if (r1) begin
                if (last1 >= 0) chk("b2b_gap_lat1", e - last1, 32'd4);
                last1 = e;
                acc1++;
            end
            if (r3) begin
                if (last3 >= 0) chk("b2b_gap_lat3", e - last3, 32'd6);
                last3 = e;
                acc3++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("b2b_count_lat1", acc1, 32'd6);
        chk("b2b_count_lat3", acc3, 32'd4);
        wait_ready();
        chk_reg("b2b_r5", 4'd5, 32'd12);

        // Reset during EXEC of a write to R4
        dbg_write(4'd4, 32'd9);
        chk_reg("pre_rst_r4", 4'd4, 32'd9);
        wait_ready();
        instr_valid = 1'b1;
        instr       = mk(4'b0000, 4'b0000, 1'b1, 4'd4, 4'd1, 4'd2);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_exec", {28'd0, d1_op}, 32'd0);
        tb_nzcv = 4'b1111;
        rst = 1'b1;
        #1;
        pulse = d1_rv;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", {31'd0, d1_ready}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            pulse = pulse | d1_rv;
            @(negedge clk);
        end
        chk("rst_mid_no_retire", {31'd0, pulse}, 32'd0);
        chk_reg("rst_mid_r4", 4'd4, 32'd0);
        chk("rst_mid_flags", {28'd0, d1_flags}, 32'd0);

        // Never-condition skips regardless of flags; then MOV of 0x80000000 with s=1 sets N
        dbg_write(4'd9, 32'h8000_0000);
        tb_nzcv = 4'b1111;
        run_instr(mk(4'b0000, 4'b1011, 1'b1, 4'd10, 4'd0, 4'd9), ex, lat, ca, cb, saw);
        chk("nv_exec", {31'd0, ex}, 32'd0);
        chk_reg("nv_r10", 4'd10, 32'd0);
        tb_nzcv = 4'b1000;
        run_instr(mk(4'b0110, 4'b0000, 1'b1, 4'd10, 4'd0, 4'd9), ex, lat, ca, cb, saw);
        chk("mov_exec", {31'd0, ex}, 32'd1);
        chk_reg("mov_r10", 4'd10, 32'h8000_0000);
        chk("mov_flags", {28'd0, d1_flags}, 32'h8);
        wait_ready();
        dbg_raddr = 4'd10;
        #1;
        chk("mov_r10_lat3", d2_rdata, 32'h8000_0000);
        chk("mov_flags_lat3", {28'd0, d2_flags}, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
